// File: rtl/cache_pkg.sv
// Shared types and defaults for the N-way set-associative write-through cache.
package cache_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int WAYS_DEF   = 4;
  localparam int SETS_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim picker: lowest invalid way of the set, otherwise the round-robin way.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim,
  output logic             evict
);

  always_comb begin
    victim = rr_ptr;
    evict  = &valid_vec;
    // Descending scan so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-through, write-allocate word cache, one word per line.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_nway
  import cache_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAYS   = WAYS_DEF,
  parameter int SETS   = SETS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  // state   | meaning
  // IDLE    | ready; tag compare and hit/miss decision on the incoming request
  // RD_MISS | read miss fetch outstanding on the memory port
  // WR_MEM  | write-through outstanding on the memory port
  // RESP    | one-cycle response pulse

  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = clog2(WAYS);

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAY_W-1:0]  rr_ptr   [SETS];

  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0]  vict_way;
  logic              vict_evict;
  logic [WAY_W-1:0]  alloc_way;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_hit;
  logic [WAY_W-1:0]  r_way;
  logic              r_evict;
  logic [DATA_W-1:0] r_rdata;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              fill;

  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IDX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:IDX_W];
  assign r_idx     = r_addr[IDX_W-1:0];
  assign r_tag     = r_addr[ADDR_W-1:IDX_W];
  assign alloc_way = hit_any ? hit_way : vict_way;
  assign fill      = (state == RD_MISS) && mem_ack;

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit_any  = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = data_mem[req_idx][w];
      end
    end
  end

  cache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid_vec (valid[req_idx]),
    .rr_ptr    (rr_ptr[req_idx]),
    .victim    (vict_way),
    .evict     (vict_evict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_wr)       state_nxt = WR_MEM;
          else if (hit_any) state_nxt = RESP;
          else              state_nxt = RD_MISS;
        end
      end
      RD_MISS: if (mem_ack) state_nxt = RESP;
      WR_MEM:  if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_hit   = (state == RESP) && r_hit;
    resp_rdata = (state == RESP) ? r_rdata : '0;
    mem_req    = (state == RD_MISS) || (state == WR_MEM);
    mem_wr     = (state == WR_MEM);
    mem_addr   = mem_req ? r_addr : '0;
    mem_wdata  = (state == WR_MEM) ? r_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_hit   <= 1'b0;
      r_way   <= '0;
      r_evict <= 1'b0;
      r_rdata <= '0;
    end else if (accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_hit   <= hit_any;
      r_way   <= alloc_way;
      r_evict <= !hit_any && vict_evict;
      r_rdata <= (!req_wr && hit_any) ? hit_data : '0;
    end else if (fill) begin
      r_rdata <= mem_rdata;
    end
  end

  // Writes allocate at accept; read misses allocate when the fill returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else if (accept && req_wr && !hit_any) begin
      valid[req_idx][vict_way] <= 1'b1;
      if (vict_evict) rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
    end else if (fill) begin
      valid[r_idx][r_way] <= 1'b1;
      if (r_evict) rr_ptr[r_idx] <= rr_ptr[r_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      data_mem[req_idx][alloc_way] <= req_wdata;
      tag_mem[req_idx][alloc_way]  <= req_tag;
    end else if (fill) begin
      data_mem[r_idx][r_way] <= mem_rdata;
      tag_mem[r_idx][r_way]  <= r_tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit_any) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
Parametrised N-way set-associative, write-through, write-allocate word cache between the core and the ram model. It replaces the fixed 2-way cache and adds:
- a valid/ready request handshake
- per-set round-robin replacement
- asynchronous reset
- configurable data width, address width, way count and set count
One word per line; memory side is a single-outstanding req/ack port.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, word-address width
WAYS, 4, associativity (power of 2, >=2)
SETS, 16, number of sets (power of 2, >=2); IDX_W=clog2(SETS), TAG_W=ADDR_W-IDX_W

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  core request present
req_ready  out  1  cache can accept request (high only in IDLE)
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle pulse, request complete
resp_hit  out  1  valid with resp_valid; 1=read hit or write hit
resp_rdata  out  DATA_W  read data, valid with resp_valid (0 for writes)
mem_req  out  1  memory request, held until mem_ack
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory done, one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Address split: index=req_addr[IDX_W-1:0], tag=req_addr[ADDR_W-1:IDX_W]. Request fields are registered on accept (req_valid && req_ready).
- Reset (rst_n low, any time, including mid-miss):
  - all valid bits, round-robin pointers and FSM state go to 0/IDLE
  - req_ready=1; resp_valid, resp_hit, mem_req, mem_wr=0
  - resp_rdata, mem_addr, mem_wdata=0
  - tag/data arrays need no reset
  - an in-flight mem_ack after reset is ignored.
- FSM states IDLE, RD_MISS, WR_MEM, RESP.
- IDLE: accept request; tag compare across all ways is combinational on the request.
  - Read hit -> RESP; resp_valid=1, resp_hit=1, data of the hit way on the next cycle. Latency 1.
  - Read miss -> RD_MISS; mem_req=1, mem_wr=0, mem_addr=addr from the next cycle.
  - Write (hit or miss) -> WR_MEM.
    - Hit way is updated on accept; a miss allocates a victim with tag/data, valid=1.
    - mem_req=1, mem_wr=1, mem_addr/mem_wdata=request from the next cycle.
- RD_MISS: on mem_ack, write mem_rdata into the victim way (tag set, valid=1), then -> RESP with resp_rdata=mem_rdata, resp_hit=0.
- WR_MEM: on mem_ack -> RESP with resp_hit=write-hit flag, resp_rdata=0.
- RESP: resp_valid high exactly one cycle, then -> IDLE; req_ready=1 in the same cycle as IDLE.
- mem_req, mem_addr and mem_wdata are stable from assertion until the mem_ack cycle inclusive; mem_req drops the cycle after ack.
- Victim selection: lowest-numbered invalid way, else way rr_ptr[index]. rr_ptr[index] increments (mod WAYS) only when a valid line is evicted.
- Multiple matching ways is impossible by construction. A write hit never allocates.
- req_valid while not ready is ignored; the requester holds it.

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs hit_cnt and miss_cnt, 32 bits each.
  - Each increments once per accepted request by hit/miss classification.
  - Saturates at 0xFFFFFFFF; reset to 0 by rst_n.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
Package cache_pkg holds:
- state enum (IDLE, RD_MISS, WR_MEM, RESP)
- clog2 function
- default width/depth constants
Sub-module cache_victim_sel: combinational; inputs valid vector (WAYS) and rr_ptr; outputs victim way index and evict flag.
Arrays, compare, FSM and counters stay in cache_nway.

Test Plan:
1. Reset, then read 0x10 with mem returning 0xAAAA after 3 cycles -> mem_req 1 cycle after accept; resp_valid, resp_hit=0, rdata=0xAAAA; a second read of 0x10 -> resp 1 cycle after accept, hit=1, no mem_req.
2. Write 0x20=0x1234 -> mem_req/mem_wr with addr 0x20, data 0x1234 held until ack; resp hit=0; then read 0x20 -> hit=1, rdata=0x1234.
3. WAYS=4, SETS=16: read 0x03,0x13,0x23,0x33 (all set 3) fill ways 0..3; read 0x43 evicts way 0 (0x03); re-read 0x13 hits; re-read 0x03 misses.
4. Assert rst_n low during RD_MISS before mem_ack, then pulse mem_ack -> no resp_valid; req_ready=1; a following read of the same address misses.
5. Hold req_valid with a new request during WR_MEM -> not accepted until the cycle after resp_valid; exactly one response per request.
6. With CACHE_STATS_EN: scenario 1 sequence -> hit_cnt=1, miss_cnt=1; reset -> both 0.
